// File: rtl/miriscv_lsu_pkg.sv
// Shared encodings for the load/store unit: access-size codes, FSM states and
// the legality/alignment rule applied when a request is accepted.
package miriscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_BUSY,
    LSU_DONE
  } lsu_state_t;

  // Unsigned sizes only make sense for loads; halfwords/words must be naturally aligned.
  function automatic logic lsu_access_ok(input logic [2:0] size, input logic we,
                                         input logic [1:0] addr_lo);
    case (size)
      LDST_B:  lsu_access_ok = 1'b1;
      LDST_H:  lsu_access_ok = ~addr_lo[0];
      LDST_W:  lsu_access_ok = (addr_lo == 2'b00);
      LDST_BU: lsu_access_ok = ~we;
      LDST_HU: lsu_access_ok = ~we & ~addr_lo[0];
      default: lsu_access_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/miriscv_lsu_if.sv
// Data-memory bus between the LSU (master) and the data memory (slave).
interface miriscv_lsu_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_rvalid;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_rdata, data_rvalid
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_rdata, data_rvalid
  );
endinterface

// File: rtl/miriscv_lsu_load_extract.sv
// Selects the addressed byte/halfword lane of a read word and sign- or
// zero-extends it according to the load size.
module miriscv_lsu_load_extract
  import miriscv_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {offset_i, 3'b000};

  // NOTE: data_o gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data_o = lane;
    case (size_i)
      LDST_B:  data_o = {{24{lane[7]}}, lane[7:0]};
      LDST_H:  data_o = {{16{lane[15]}}, lane[15:0]};
      LDST_BU: data_o = {24'b0, lane[7:0]};
      LDST_HU: data_o = {16'b0, lane[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: runs one data-memory transaction per decoded memory op and
// stalls the core until the result (load data or error) is ready.
module miriscv_lsu
  import miriscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          lsu_req_i,
  input  logic          lsu_we_i,
  input  logic [2:0]    lsu_size_i,
  input  logic [31:0]   lsu_addr_i,
  input  logic [31:0]   lsu_wdata_i,
  output logic [31:0]   lsu_rdata_o,
  output logic          lsu_stall_o,
  output logic          lsu_err_o,
  miriscv_lsu_if.master data_bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        data_req_q;
  logic        data_we_q;
  logic [3:0]  data_be_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        ok_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [31:0] rdata_d;

  assign ok_d = lsu_access_ok(lsu_size_i, lsu_we_i, lsu_addr_i[1:0]);

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_size_i)
      LDST_B, LDST_BU: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      LDST_H, LDST_HU: begin
        be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  miriscv_lsu_load_extract u_load_extract (
    .rdata_i  (data_bus.data_rdata),
    .offset_i (addr_lo_q),
    .size_i   (size_q),
    .data_o   (rdata_d)
  );

  // NOTE: all state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= LSU_IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      addr_lo_q    <= '0;
      data_req_q   <= 1'b0;
      data_we_q    <= 1'b0;
      data_be_q    <= '0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            size_q    <= lsu_size_i;
            addr_lo_q <= lsu_addr_i[1:0];
            if (ok_d) begin
              state_q      <= LSU_BUSY;
              cnt_q        <= '0;
              data_req_q   <= 1'b1;
              data_we_q    <= lsu_we_i;
              data_be_q    <= be_d;
              data_addr_q  <= {lsu_addr_i[31:2], 2'b00};
              data_wdata_q <= wdata_d;
            end else begin
              state_q <= LSU_DONE;
              err_q   <= 1'b1;
            end
          end
        end
        LSU_BUSY: begin
          // A request withdrawn mid-access still drains the bus, but its result is dropped.
          if (data_bus.data_rvalid || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= lsu_req_i ? LSU_DONE : LSU_IDLE;
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            data_be_q    <= '0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
            err_q        <= lsu_req_i & ~data_bus.data_rvalid;
            rdata_q      <= (lsu_req_i && data_bus.data_rvalid && !data_we_q) ? rdata_d : '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        LSU_DONE: begin
          state_q <= LSU_IDLE;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign lsu_stall_o = lsu_req_i & (state_q != LSU_DONE);
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;

  assign data_bus.data_req   = data_req_q;
  assign data_bus.data_we    = data_we_q;
  assign data_bus.data_be    = data_be_q;
  assign data_bus.data_addr  = data_addr_q;
  assign data_bus.data_wdata = data_wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu: a table of single accesses plus hand-written
// sequences for timeout, reset mid-access and a withdrawn request.
module tb_miriscv_lsu;
  import miriscv_lsu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [2:0]  lsu_size_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [31:0] lsu_rdata_o;
  logic        lsu_stall_o;
  logic        lsu_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  miriscv_lsu_if bus ();

  miriscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lsu_req_i   (lsu_req_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_size_i  (lsu_size_i),
    .lsu_addr_i  (lsu_addr_i),
    .lsu_wdata_i (lsu_wdata_i),
    .lsu_rdata_o (lsu_rdata_o),
    .lsu_stall_o (lsu_stall_o),
    .lsu_err_o   (lsu_err_o),
    .data_bus    (bus.master)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata;
    logic        bus_used;
    logic [3:0]  be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata);
    lsu_req_i   = 1'b1;
    lsu_we_i    = we;
    lsu_size_i  = size;
    lsu_addr_i  = addr;
    lsu_wdata_i = wdata;
  endtask

  // Request at cycle 0, optional rvalid at cycle 1, result checked in the DONE cycle.
  task automatic do_vec(input vec_t v);
    @(negedge clk_i);
    drive_req(v.we, v.size, v.addr, v.wdata);
    #1;
    check({v.name, " stall c0"}, 32'(lsu_stall_o), 32'd1);
    @(negedge clk_i);
    if (v.bus_used) begin
      check({v.name, " req c1"},   32'(bus.data_req), 32'd1);
      check({v.name, " we"},       32'(bus.data_we), 32'(v.we));
      check({v.name, " be"},       32'(bus.data_be), 32'(v.be));
      check({v.name, " addr"},     bus.data_addr, v.bus_addr);
      check({v.name, " wdata"},    bus.data_wdata, v.bus_wdata);
      check({v.name, " stall c1"}, 32'(lsu_stall_o), 32'd1);
      bus.data_rvalid = 1'b1;
      bus.data_rdata  = v.mem_rdata;
      @(negedge clk_i);
      bus.data_rvalid = 1'b0;
      bus.data_rdata  = 32'h0;
    end
    check({v.name, " req done"},   32'(bus.data_req), 32'd0);
    check({v.name, " stall done"}, 32'(lsu_stall_o), 32'd0);
    check({v.name, " rdata"},      lsu_rdata_o, v.rdata);
    check({v.name, " err"},        32'(lsu_err_o), 32'(v.err));
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    check({v.name, " err clr"},   32'(lsu_err_o), 32'd0);
    check({v.name, " rdata clr"}, lsu_rdata_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //          name         we    size     addr          wdata         mem_rdata     bus   be       bus_addr      bus_wdata     rdata         err
    vecs[0]  = '{"lw 104",   1'b0, LDST_W,  32'h0000_0104, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0000_0104, 32'h1122_3344, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{"lb 103",   1'b0, LDST_B,  32'h0000_0103, 32'h0000_0000, 32'h8012_3456, 1'b1, 4'b1000, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_FF80, 1'b0};
    vecs[2]  = '{"lbu 103",  1'b0, LDST_BU, 32'h0000_0103, 32'h0000_0000, 32'h8012_3456, 1'b1, 4'b1000, 32'h0000_0100, 32'h0000_0000, 32'h0000_0080, 1'b0};
    vecs[3]  = '{"sh 202",   1'b1, LDST_H,  32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h0000_0000, 1'b0};
    vecs[4]  = '{"lw 102",   1'b0, LDST_W,  32'h0000_0102, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5]  = '{"size3",    1'b0, 3'd3,    32'h0000_0100, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[6]  = '{"lh 102",   1'b0, LDST_H,  32'h0000_0102, 32'h0000_0000, 32'h8001_1234, 1'b1, 4'b1100, 32'h0000_0100, 32'h0000_0000, 32'hFFFF_8001, 1'b0};
    vecs[7]  = '{"lhu 100",  1'b0, LDST_HU, 32'h0000_0100, 32'h0000_0000, 32'h1234_F00D, 1'b1, 4'b0011, 32'h0000_0100, 32'h0000_0000, 32'h0000_F00D, 1'b0};
    vecs[8]  = '{"sb 101",   1'b1, LDST_B,  32'h0000_0101, 32'h1234_56A5, 32'hFFFF_FFFF, 1'b1, 4'b0010, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    vecs[9]  = '{"sw 300",   1'b1, LDST_W,  32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 4'b1111, 32'h0000_0300, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[10] = '{"lh 101",   1'b0, LDST_H,  32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[11] = '{"sbu",      1'b1, LDST_BU, 32'h0000_0100, 32'h0000_00FF, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{"lb 102",   1'b0, LDST_B,  32'h0000_0102, 32'h0000_0000, 32'h007F_0000, 1'b1, 4'b0100, 32'h0000_0100, 32'h0000_0000, 32'h0000_007F, 1'b0};
    vecs[13] = '{"sh 201",   1'b1, LDST_H,  32'h0000_0201, 32'h0000_1111, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};

    rst_i           = 1'b1;
    lsu_req_i       = 1'b1;
    lsu_we_i        = 1'b0;
    lsu_size_i      = LDST_W;
    lsu_addr_i      = 32'h0;
    lsu_wdata_i     = 32'h0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'h0;

    // Reset state: stall follows the request even while reset is held.
    repeat (2) @(negedge clk_i);
    check("rst stall req=1", 32'(lsu_stall_o), 32'd1);
    lsu_req_i = 1'b0;
    #1;
    check("rst stall req=0", 32'(lsu_stall_o), 32'd0);
    check("rst data_req",   32'(bus.data_req), 32'd0);
    check("rst be",         32'(bus.data_be), 32'd0);
    check("rst addr",       bus.data_addr, 32'h0);
    check("rst rdata",      lsu_rdata_o, 32'h0);
    check("rst err",        32'(lsu_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 14; i++) do_vec(vecs[i]);

    // Store with rvalid withheld: four BUSY cycles, then a timeout error.
    @(negedge clk_i);
    drive_req(1'b1, LDST_W, 32'h0000_0400, 32'h0000_0001);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (bus.data_req) cnt++;
      else break;
    end
    check("timeout req cycles", 32'(cnt), 32'd4);
    check("timeout stall",      32'(lsu_stall_o), 32'd0);
    check("timeout err",        32'(lsu_err_o), 32'd1);
    check("timeout rdata",      lsu_rdata_o, 32'h0);
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    check("timeout err clr", 32'(lsu_err_o), 32'd0);

    // Reset while BUSY, then a stray rvalid that must be ignored.
    drive_req(1'b0, LDST_W, 32'h0000_0500, 32'h0);
    @(negedge clk_i);
    check("rstbusy req c1", 32'(bus.data_req), 32'd1);
    lsu_req_i = 1'b0;
    rst_i     = 1'b1;
    #1;
    check("rstbusy req now", 32'(bus.data_req), 32'd0);
    check("rstbusy be now",  32'(bus.data_be), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h5555_AAAA;
    @(negedge clk_i);
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'h0;
    check("late rvalid rdata", lsu_rdata_o, 32'h0);
    check("late rvalid err",   32'(lsu_err_o), 32'd0);
    check("late rvalid req",   32'(bus.data_req), 32'd0);
    do_vec(vecs[0]);

    // Request withdrawn in BUSY: the access drains to IDLE without a DONE cycle.
    @(negedge clk_i);
    drive_req(1'b0, LDST_W, 32'h0000_0600, 32'h0);
    @(negedge clk_i);
    check("drop req c1", 32'(bus.data_req), 32'd1);
    lsu_req_i       = 1'b0;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h0000_0055;
    @(negedge clk_i);
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'h0;
    check("drop req bus",   32'(bus.data_req), 32'd0);
    check("drop req rdata", lsu_rdata_o, 32'h0);
    check("drop req err",   32'(lsu_err_o), 32'd0);
    drive_req(1'b0, LDST_W, 32'h0000_0604, 32'h0);
    #1;
    check("drop next stall", 32'(lsu_stall_o), 32'd1);
    @(negedge clk_i);
    check("drop next req",  32'(bus.data_req), 32'd1);
    check("drop next addr", bus.data_addr, 32'h0000_0604);
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h0BAD_F00D;
    @(negedge clk_i);
    bus.data_rvalid = 1'b0;
    check("drop next rdata", lsu_rdata_o, 32'h0BAD_F00D);
    check("drop next stall done", 32'(lsu_stall_o), 32'd0);
    lsu_req_i = 1'b0;
    @(negedge clk_i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
